// File: rtl/shift_seq_pkg.sv
// Shared types and sizing for the multi-cycle left-shift sequencer.
package shift_seq_pkg;

  localparam int DATA_W   = 8;
  localparam int AMT_W    = 5;
  localparam int STEP_W   = 3;
  localparam int MAX_STEP = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage_l8.sv
// Combinational DATA_W-bit left shift by up to MAX_STEP positions, zero-filled.
// With SHIFT_OVF_EN defined it also exposes the bits pushed out of the MSB end.
module shift_stage_l8
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [STEP_W-1:0] i_amt,
  output logic [DATA_W-1:0] o_data
`ifdef SHIFT_OVF_EN
  ,
  output logic [DATA_W-1:0] o_spill
`endif
);

`ifdef SHIFT_OVF_EN
  logic [2*DATA_W-1:0] w_wide;

  // Widen first so the bits leaving the top are kept in the upper half.
  assign w_wide  = {{DATA_W{1'b0}}, i_data} << i_amt;
  assign o_data  = w_wide[DATA_W-1:0];
  assign o_spill = w_wide[2*DATA_W-1:DATA_W];
`else
  assign o_data = i_data << i_amt;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle left-shift sequencer: applies up to 31 positions as passes of at most
// 7 through shift_stage_l8. Optional overflow flag under SHIFT_OVF_EN.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef SHIFT_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_acc;
  logic [AMT_W-1:0]    r_rem;
  logic [STEP_W-1:0]   w_step;
  logic [AMT_W-1:0]    w_remNext;
  logic [DATA_W-1:0]   w_shifted;
  logic                w_accept;
`ifdef SHIFT_OVF_EN
  logic [DATA_W-1:0]   w_spill;
  logic                r_ovf;
`endif

  // Each pass takes as much of the remaining amount as one stage can apply.
  assign w_step    = (r_rem > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : r_rem[STEP_W-1:0];
  assign w_remNext = r_rem - AMT_W'(w_step);
  assign w_accept  = in_valid && (r_state == IDLE);

  shift_stage_l8 u_stage (
    .i_data  (r_acc),
    .i_amt   (w_step),
    .o_data  (w_shifted)
`ifdef SHIFT_OVF_EN
    ,
    .o_spill (w_spill)
`endif
  );

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = r_acc;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_remNext == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= in_data;
        r_rem <= in_amt;
      end else if (r_state == SHIFT) begin
        r_acc <= w_shifted;
        r_rem <= w_remNext;
      end
    end
  end

`ifdef SHIFT_OVF_EN
  // Sticky across passes so the flag covers the whole request, not just the last pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_ovf <= r_ovf | (|w_spill);
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model. Honours SHIFT_OVF_EN.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef SHIFT_OVF_EN
  logic       out_ovf;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SHIFT_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request occupies the unit for ceil(amt/7) shift cycles,
  // then its result is offered until taken. The result is simply (data << amt) mod 256.
  bit       mBusy = 0;
  bit       mValid = 0;
  int       mWait = 0;
  bit [7:0] mRes = 0;
  bit       mOvfRes = 0;
  bit [7:0] mLast = 0;

  always @(posedge clk) begin
    longint full;
    if (rst) begin
      mBusy  = 0;
      mValid = 0;
      mWait  = 0;
      mLast  = 0;
    end else if (!mBusy) begin
      if (in_valid) begin
        full    = longint'(in_data) << in_amt;
        mRes    = full[7:0];
        mOvfRes = (full[39:8] != 0);
        mBusy   = 1;
        mWait   = (int'(in_amt) + 6) / 7;
        mValid  = (mWait == 0);
      end
    end else if (!mValid) begin
      mWait--;
      if (mWait == 0) mValid = 1;
    end else if (out_ready) begin
      mValid = 0;
      mBusy  = 0;
      mLast  = mRes;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!mBusy));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) begin
        checkOutput("out_data", 32'(out_data), 32'(mRes));
`ifdef SHIFT_OVF_EN
        checkOutput("out_ovf", 32'(out_ovf), 32'(mOvfRes));
`endif
      end else if (!mBusy) begin
        checkOutput("idle_data", 32'(out_data), 32'(mLast));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic [4:0] a, input int hold,
                               input logic [7:0] expData, input logic expOvf, input int expLat);
    int guard;
    int lat;
    in_data   = d;
    in_amt    = a;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("result", 32'(out_data), 32'(expData));
`ifdef SHIFT_OVF_EN
    checkOutput("ovf", 32'(out_ovf), 32'(expOvf));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      in_amt   = 5'd0;
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", 32'(out_data), 32'(expData));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("taken", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkEn = 1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'h81, 5'd3, 0, 8'h08, 1'b1, 2);
    applyStimulus(8'h5A, 5'd0, 0, 8'h5A, 1'b0, 1);
    applyStimulus(8'h01, 5'd7, 0, 8'h80, 1'b0, 2);
    applyStimulus(8'h01, 5'd14, 0, 8'h00, 1'b1, 3);
    applyStimulus(8'hFF, 5'd31, 0, 8'h00, 1'b1, 6);
    applyStimulus(8'h13, 5'd2, 4, 8'h4C, 1'b0, 2);

    // Abort a long request partway through its passes.
    in_data  = 8'hC3;
    in_amt   = 5'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_data", 32'(out_data), 32'd0);
    @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_data   = 8'($urandom);
      in_amt    = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
